demux32_1_2_buf: RTL and testbench
==================================

# demux32_1_2_buf

Registered 1-to-2 demultiplexer that steers a 32-bit data stream to one of two downstream consumers, selected per word by `in_sel`. It is the inverse of the datapath's 2:1 select: `in_sel`=0 routes to port A and `in_sel`=1 routes to port B. Each output has its own small FIFO, so a stalled consumer does not block words bound for the other, unless the next input word is bound for the stalled one. The block sits between a single producer and two consumers. Typical use is splitting a result stream between write-back and store paths.

## Interface
Parameters:
- `WIDTH`, 32, data width of input and both outputs
- `DEPTH`, 2, entries per output FIFO; power of two, ≥2

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  synchronous active-low reset, sampled on `clk` rising edge
- `in_data`  in  WIDTH  input word
- `in_sel`  in  1  destination: 0 → A, 1 → B
- `in_valid`  in  1  producer offers `in_data`/`in_sel`
- `in_ready`  out  1  block accepts this cycle
- `a_data`  out  WIDTH  head of FIFO A
- `a_valid`  out  1  FIFO A non-empty
- `a_ready`  in  1  consumer A takes head
- `b_data`  out  WIDTH  head of FIFO B
- `b_valid`  out  1  FIFO B non-empty
- `b_ready`  in  1  consumer B takes head
- `a_count`  out  $clog2(DEPTH)+1  occupancy of FIFO A
- `b_count`  out  $clog2(DEPTH)+1  occupancy of FIFO B

## Operation
- Accept: `in_ready` = NOT full(FIFO[`in_sel`]). This is combinational from `in_sel` and the occupancy registers, and is independent of `in_valid`.
- Push: on `in_valid && in_ready`, write `in_data` into FIFO A if `in_sel`=0, otherwise into FIFO B. The other FIFO is untouched.
- Pop: on `x_valid && x_ready`, advance FIFO x read pointer. `x_ready` while `x_valid`=0 is ignored.
- Ordering: FIFO order is preserved per output. There is no ordering guarantee between A and B.
- Full FIFO: pushes are rejected (`in_ready`=0) even if the same FIFO pops in that cycle. There is no full-pass-through.
- Empty FIFO: there is no fall-through. A word pushed into an empty FIFO appears on `x_data` the next cycle.
- Simultaneous push and pop on a non-full, non-empty FIFO: the count is unchanged and both pointers advance.
- Simultaneous push to A and pop from B is legal. Both FIFOs operate independently in the same cycle.
- Pointer wrap: pointers are `$clog2(DEPTH)` bits and wrap modulo DEPTH. The count is tracked separately, so full and empty are unambiguous.
- Producer protocol: `in_data`/`in_sel` must be held while `in_valid`=1 and `in_ready`=0. The block does not check this.
- Reset (`rst_n`=0 at an edge): pointers and counts go to 0 and storage is cleared to 0. Any words in flight are discarded.

## Timing
- Reset values: `a_valid`=`b_valid`=0, `a_count`=`b_count`=0, `a_data`=`b_data`=0. `in_ready`=1 for either `in_sel`.
- Latency: a word accepted at edge N appears on `x_data`/`x_valid` after edge N, i.e. in cycle N+1.
- Throughput: one word per cycle into each FIFO as long as it is not full. With DEPTH=2 and a consumer that never stalls, the stream runs at full rate with no bubbles.
- `x_data` is registered (FIFO head storage) and is stable while `x_valid`=1 and `x_ready`=0.
- Reset mid-operation takes effect at the sampling edge. In the cycle after that edge all outputs show reset values, regardless of handshakes in the reset cycle.

## Structure
- Shared package `cpu_pkg`:
  - constants `SEL_A`=1'b0 and `SEL_B`=1'b1
  - `DATA_W`=32, used as the WIDTH default
- One sub-module, `sync_fifo_buf`, instantiated twice (A, B). It has parameters WIDTH and DEPTH and ports clk, rst_n, push, wdata, pop, rdata, full, empty, count.
- The top level holds only the select steering (push enables) and the `in_ready` mux.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles with `in_valid`=1. Required: no push, both valids 0, both counts 0, `in_ready`=1.
- Steering: push 0x0000_00A1 (sel 0) then 0x0000_00B1 (sel 1), with both readies held 1. Required: `a_data`=0x0000_00A1 one cycle after its accept; `b_data`=0x0000_00B1 one cycle after its accept; the other port's valid stays 0.
- Backpressure and full: `a_ready`=0; push 0x1, 0x2, 0x3 to A. Required:
  - `a_count`=2 and `in_ready`=0 while the third word is offered;
  - after `a_ready`=1, A delivers 0x1, 0x2, 0x3 in order.
- Independence: A is full and stalled; push 0x55 to B. Required: `in_ready`=1, the push is accepted, and `b_data`=0x55 next cycle.
- Full plus pop same cycle: A full, `a_ready`=1, offer 0x9 to A. Required: `in_ready`=0 that cycle, `a_count`=1 next cycle; 0x9 is accepted the following cycle.
- Wrap and reset mid-stream: stream 0x1 through 0xA to B with `b_ready` toggling every cycle, so the pointers wrap several times. Required: B delivers 0x1 to 0xA in order with no loss. Then assert reset with B holding 2 entries. Required: `b_count`=0 and `b_valid`=0 in the cycle after the reset edge.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared constants for the datapath: default data width and demux select encodings.
package cpu_pkg;

    localparam int unsigned DATA_W = 32;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/demux32_1_2_buf_fifo.sv
// sync_fifo_buf: small synchronous FIFO with registered storage, separate occupancy
// counter (so full/empty never alias) and no fall-through or full-pass-through.
module sync_fifo_buf #(
    parameter int unsigned WIDTH = cpu_pkg::DATA_W,
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;

    logic w_push;
    logic w_pop;

    // Guard the handshakes locally so a push into a full or pop from an empty FIFO is a no-op.
    always_comb begin
        w_push = push && !full;
        w_pop  = pop  && !empty;
    end

    // Storage, pointers and occupancy; reset clears everything including the storage.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= wdata;
                r_wptr        <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Status and head-of-queue view, all derived from registered state.
    always_comb begin
        full  = (r_count == CNT_W'(DEPTH));
        empty = (r_count == '0);
        rdata = r_mem[r_rptr];
        count = r_count;
    end

endmodule

// File: rtl/demux32_1_2_buf.sv
// demux32_1_2_buf: steers each input word to FIFO A (sel=0) or FIFO B (sel=1);
// each consumer drains its own FIFO so one stall does not block the other port.
module demux32_1_2_buf
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_W,
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     in_sel,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [WIDTH-1:0]         a_data,
    output logic                     a_valid,
    input  logic                     a_ready,
    output logic [WIDTH-1:0]         b_data,
    output logic                     b_valid,
    input  logic                     b_ready,
    output logic [$clog2(DEPTH):0]   a_count,
    output logic [$clog2(DEPTH):0]   b_count
);

    logic w_full_a;
    logic w_full_b;
    logic w_empty_a;
    logic w_empty_b;
    logic w_push_a;
    logic w_push_b;

    // Ready depends only on the selected FIFO's fullness, never on in_valid.
    always_comb begin
        in_ready = (in_sel == SEL_B) ? !w_full_b : !w_full_a;
        w_push_a = in_valid && in_ready && (in_sel == SEL_A);
        w_push_b = in_valid && in_ready && (in_sel == SEL_B);
        a_valid  = !w_empty_a;
        b_valid  = !w_empty_b;
    end

    sync_fifo_buf #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo_a (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push_a),
        .wdata (in_data),
        .pop   (a_ready),
        .rdata (a_data),
        .full  (w_full_a),
        .empty (w_empty_a),
        .count (a_count)
    );

    sync_fifo_buf #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo_b (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push_b),
        .wdata (in_data),
        .pop   (b_ready),
        .rdata (b_data),
        .full  (w_full_b),
        .empty (w_empty_b),
        .count (b_count)
    );

endmodule

// File: tb/tb_demux32_1_2_buf.sv
// Bench for demux32_1_2_buf: directed scenarios plus a randomized run, all checked
// against a queue-based model of two independent bounded FIFOs.
module tb_demux32_1_2_buf;

    localparam int unsigned W     = 32;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic          clk;
    logic          rst_n;
    logic [W-1:0]  in_data;
    logic          in_sel;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a_data;
    logic          a_valid;
    logic          a_ready;
    logic [W-1:0]  b_data;
    logic          b_valid;
    logic          b_ready;
    logic [CW-1:0] a_count;
    logic [CW-1:0] b_count;

    demux32_1_2_buf #(.WIDTH(W), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a_data   (a_data),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .b_data   (b_data),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .a_count  (a_count),
        .b_count  (b_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: contents of each FIFO, oldest first.
    logic [W-1:0] qa[$];
    logic [W-1:0] qb[$];
    // Words observed leaving each port (sampled pre-edge when valid && ready).
    logic [W-1:0] dlv_a[$];
    logic [W-1:0] dlv_b[$];
    logic obs_rdy;
    logic exp_rdy;
    logic last_acc;

    // One clock cycle: drive inputs, sample pre-edge, advance model at the edge.
    task automatic cycle(input logic v, input logic s, input logic [W-1:0] d,
                         input logic ar, input logic br, input logic rn);
        int sz;
        in_valid = v; in_sel = s; in_data = d;
        a_ready = ar; b_ready = br; rst_n = rn;
        #1;
        obs_rdy = in_ready;
        sz = s ? qb.size() : qa.size();
        exp_rdy = (sz < int'(DEPTH));
        if (rn && a_valid === 1'b1 && ar) dlv_a.push_back(a_data);
        if (rn && b_valid === 1'b1 && br) dlv_b.push_back(b_data);
        @(posedge clk);
        last_acc = rn && v && exp_rdy;
        if (!rn) begin
            qa.delete();
            qb.delete();
        end else begin
            if (ar && qa.size() > 0) void'(qa.pop_front());
            if (br && qb.size() > 0) void'(qb.pop_front());
            if (last_acc) begin
                if (s) qb.push_back(d);
                else   qa.push_back(d);
            end
        end
        #1;
    endtask

    task automatic test_reset();
        cycle(1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 32'hCAFE_F00D, 1'b0, 1'b0, 1'b0);
        n_checks++; if (obs_rdy !== 1'b1) $display("FAIL reset_in_ready_sel1 got %b exp 1", obs_rdy); else n_pass++;
        in_valid = 1'b1; in_sel = 1'b0; #1;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready_sel0 got %b exp 1", in_ready); else n_pass++;
        n_checks++; if (a_valid !== 1'b0 || b_valid !== 1'b0) $display("FAIL reset_valids got a=%b b=%b exp 0 0", a_valid, b_valid); else n_pass++;
        n_checks++; if (a_count !== '0 || b_count !== '0) $display("FAIL reset_counts got a=%0d b=%0d exp 0 0", a_count, b_count); else n_pass++;
        n_checks++; if (a_data !== '0 || b_data !== '0) $display("FAIL reset_data got a=%h b=%h exp 0 0", a_data, b_data); else n_pass++;
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b1);
    endtask

    task automatic test_steering();
        cycle(1'b1, 1'b0, 32'h0000_00A1, 1'b1, 1'b1, 1'b1);
        n_checks++; if (obs_rdy !== 1'b1) $display("FAIL steer_a_ready got %b exp 1", obs_rdy); else n_pass++;
        n_checks++; if (a_valid !== 1'b1 || a_data !== 32'h0000_00A1) $display("FAIL steer_a_out got v=%b d=%h exp 1 000000a1", a_valid, a_data); else n_pass++;
        n_checks++; if (b_valid !== 1'b0) $display("FAIL steer_b_idle got %b exp 0", b_valid); else n_pass++;
        cycle(1'b1, 1'b1, 32'h0000_00B1, 1'b1, 1'b1, 1'b1);
        n_checks++; if (b_valid !== 1'b1 || b_data !== 32'h0000_00B1) $display("FAIL steer_b_out got v=%b d=%h exp 1 000000b1", b_valid, b_data); else n_pass++;
        n_checks++; if (a_valid !== 1'b0) $display("FAIL steer_a_drained got %b exp 0", a_valid); else n_pass++;
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b1);
        n_checks++; if (b_valid !== 1'b0) $display("FAIL steer_b_drained got %b exp 0", b_valid); else n_pass++;
    endtask

    task automatic test_backpressure();
        dlv_a.delete();
        cycle(1'b1, 1'b0, 32'h1, 1'b0, 1'b1, 1'b1);
        cycle(1'b1, 1'b0, 32'h2, 1'b0, 1'b1, 1'b1);
        n_checks++; if (a_count !== CW'(2)) $display("FAIL bp_count got %0d exp 2", a_count); else n_pass++;
        cycle(1'b1, 1'b0, 32'h3, 1'b0, 1'b1, 1'b1);
        n_checks++; if (obs_rdy !== 1'b0) $display("FAIL bp_full_ready got %b exp 0", obs_rdy); else n_pass++;
        n_checks++; if (a_count !== CW'(2) || a_data !== 32'h1) $display("FAIL bp_hold got cnt=%0d d=%h exp 2 00000001", a_count, a_data); else n_pass++;
    endtask

    task automatic test_independence();
        cycle(1'b1, 1'b1, 32'h55, 1'b0, 1'b0, 1'b1);
        n_checks++; if (obs_rdy !== 1'b1) $display("FAIL indep_ready got %b exp 1", obs_rdy); else n_pass++;
        n_checks++; if (b_valid !== 1'b1 || b_data !== 32'h55) $display("FAIL indep_b_out got v=%b d=%h exp 1 00000055", b_valid, b_data); else n_pass++;
        n_checks++; if (a_count !== CW'(2)) $display("FAIL indep_a_untouched got %0d exp 2", a_count); else n_pass++;
        cycle(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b1);
        n_checks++; if (b_count !== '0) $display("FAIL indep_b_drain got %0d exp 0", b_count); else n_pass++;
    endtask

    task automatic test_full_pop();
        cycle(1'b1, 1'b0, 32'h3, 1'b1, 1'b0, 1'b1);
        n_checks++; if (obs_rdy !== 1'b0) $display("FAIL fullpop_ready got %b exp 0", obs_rdy); else n_pass++;
        n_checks++; if (a_count !== CW'(1) || a_data !== 32'h2) $display("FAIL fullpop_after got cnt=%0d d=%h exp 1 00000002", a_count, a_data); else n_pass++;
        cycle(1'b1, 1'b0, 32'h3, 1'b1, 1'b0, 1'b1);
        n_checks++; if (obs_rdy !== 1'b1) $display("FAIL fullpop_accept got %b exp 1", obs_rdy); else n_pass++;
        n_checks++; if (a_count !== CW'(1) || a_data !== 32'h3) $display("FAIL fullpop_pushpop got cnt=%0d d=%h exp 1 00000003", a_count, a_data); else n_pass++;
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b1);
        n_checks++; if (dlv_a.size() != 3 || dlv_a[0] !== 32'h1 || dlv_a[1] !== 32'h2 || dlv_a[2] !== 32'h3)
            $display("FAIL bp_order got n=%0d exp 3 words 1,2,3", dlv_a.size()); else n_pass++;
        n_checks++; if (a_valid !== 1'b0) $display("FAIL fullpop_empty got %b exp 0", a_valid); else n_pass++;
    endtask

    task automatic test_wrap_reset();
        logic [W-1:0] nxt;
        int guard;
        bit ok;
        dlv_b.delete();
        nxt = 32'h1;
        guard = 0;
        while ((nxt <= 32'hA || b_valid === 1'b1) && guard < 200) begin
            cycle(nxt <= 32'hA, 1'b1, nxt, 1'b0, guard[0], 1'b1);
            if (last_acc) nxt = nxt + 32'h1;
            guard++;
        end
        n_checks++; if (guard >= 200) $display("FAIL wrap_timeout got %0d cycles exp < 200", guard); else n_pass++;
        ok = (dlv_b.size() == 10);
        for (int i = 0; i < dlv_b.size(); i++) if (dlv_b[i] !== W'(i + 1)) ok = 1'b0;
        n_checks++; if (!ok) $display("FAIL wrap_order got n=%0d exp 10 words 1..10", dlv_b.size()); else n_pass++;
        cycle(1'b1, 1'b1, 32'h11, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 32'h12, 1'b0, 1'b0, 1'b1);
        n_checks++; if (b_count !== CW'(2)) $display("FAIL wrap_fill got %0d exp 2", b_count); else n_pass++;
        cycle(1'b1, 1'b0, 32'h13, 1'b1, 1'b1, 1'b0);
        n_checks++; if (b_count !== '0 || b_valid !== 1'b0 || b_data !== '0) $display("FAIL midreset_b got cnt=%0d v=%b d=%h exp 0 0 0", b_count, b_valid, b_data); else n_pass++;
        n_checks++; if (a_count !== '0 || a_valid !== 1'b0) $display("FAIL midreset_a got cnt=%0d v=%b exp 0 0", a_count, a_valid); else n_pass++;
    endtask

    task automatic test_random();
        logic v, s, ar, br, rn, pend, just_rst;
        logic [W-1:0] d;
        pend = 1'b0; s = 1'b0; d = '0; just_rst = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (!pend) begin
                v = ($urandom_range(0, 3) != 0);
                s = 1'(($urandom_range(0, 1)));
                d = $urandom;
            end else begin
                v = 1'b1;
            end
            ar = ($urandom_range(0, 2) != 0);
            br = ($urandom_range(0, 2) != 0);
            rn = ($urandom_range(0, 59) != 0);
            cycle(v, s, d, ar, br, rn);
            pend = v && !last_acc && rn;
            n_checks++; if (obs_rdy !== exp_rdy) $display("FAIL rnd_in_ready cyc %0d got %b exp %b", n, obs_rdy, exp_rdy); else n_pass++;
            n_checks++; if (a_count !== CW'(qa.size()) || a_valid !== (qa.size() > 0))
                $display("FAIL rnd_a_state cyc %0d got cnt=%0d v=%b exp %0d", n, a_count, a_valid, qa.size()); else n_pass++;
            n_checks++; if (b_count !== CW'(qb.size()) || b_valid !== (qb.size() > 0))
                $display("FAIL rnd_b_state cyc %0d got cnt=%0d v=%b exp %0d", n, b_count, b_valid, qb.size()); else n_pass++;
            if (qa.size() > 0) begin
                n_checks++; if (a_data !== qa[0]) $display("FAIL rnd_a_data cyc %0d got %h exp %h", n, a_data, qa[0]); else n_pass++;
            end
            if (qb.size() > 0) begin
                n_checks++; if (b_data !== qb[0]) $display("FAIL rnd_b_data cyc %0d got %h exp %h", n, b_data, qb[0]); else n_pass++;
            end
            just_rst = !rn;
            if (just_rst) begin
                n_checks++; if (a_data !== '0 || b_data !== '0) $display("FAIL rnd_reset_data cyc %0d got a=%h b=%h exp 0 0", n, a_data, b_data); else n_pass++;
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_sel = 1'b0; in_data = '0;
        a_ready = 1'b0; b_ready = 1'b0;
        test_reset();
        test_steering();
        test_backpressure();
        test_independence();
        test_full_pop();
        test_wrap_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
